// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter: round-robin front end that lends one 3-bit Gray counter to NREQ clients.
// Build option GRAY_SEQ_CHECK_EN adds a sticky Gray-sequence checker on SeqErr.
module gray_step_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   Req,
  input  logic [3*NREQ-1:0] Steps,
  output logic [NREQ-1:0]   Gnt,
  output logic [NREQ-1:0]   Done,
  output logic              WrapNew,
  output logic              Busy,
  output logic              CntEn,
  output logic              CntReset,
  input  logic              CntOverflow,
  input  logic [2:0]        CntValue,
  output logic              SeqErr,
  output logic [1:0]        DbgState
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

  // Handshake: a requester holds Req until its one-cycle Done pulse; Gnt marks the
  // owner from GRANT through DONE, and Req/Steps are ignored once the job is latched.
  state_t          state, state_n;
  logic [IW-1:0]   ptr, win, pick;
  logic [2:0]      rem;
  logic            is_rst, ovf0;
  logic [NREQ-1:0] win_oh;

  // Nearest set request after the pointer wins; scanning far-to-near leaves it last.
  always_comb begin
    pick = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (Req[(int'(ptr) + k) % NREQ]) pick = IW'((int'(ptr) + k) % NREQ);
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NREQ; i++) win_oh[i] = (int'(win) == i);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ - 1);
      win    <= '0;
      rem    <= 3'd0;
      is_rst <= 1'b0;
      ovf0   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (|Req) win <= pick;
        GRANT: begin
          rem    <= Steps[3*int'(win) +: 3];
          is_rst <= (Steps[3*int'(win) +: 3] == 3'd0);
          ovf0   <= CntOverflow;
          ptr    <= win;
        end
        RUN: if (!is_rst) rem <= rem - 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    CntEn    = 1'b0;
    CntReset = 1'b0;
    case (state)
      IDLE:  if (|Req) state_n = GRANT;
      GRANT: state_n = RUN;
      RUN: begin
        if (is_rst) begin
          CntReset = 1'b1;
          state_n  = DONE;
        end else begin
          CntEn = 1'b1;
          if (rem == 3'd1) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign Busy     = (state != IDLE);
  assign Gnt      = Busy ? win_oh : '0;
  assign Done     = (state == DONE) ? win_oh : '0;
  assign WrapNew  = (state == DONE) && CntOverflow && !ovf0 && !is_rst;
  assign DbgState = state;

`ifdef GRAY_SEQ_CHECK_EN
  logic       en_q, rst_q, seq_err;
  logic [2:0] val_q, diff;

  assign diff = CntValue ^ val_q;

  // After an En cycle exactly one bit may change; after a counter reset it must read zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      val_q   <= 3'd0;
      seq_err <= 1'b0;
    end else begin
      en_q  <= CntEn;
      rst_q <= CntReset;
      val_q <= CntValue;
      if ((en_q && (diff == 3'd0 || (diff & (diff - 3'd1)) != 3'd0)) ||
          (rst_q && CntValue != 3'd0))
        seq_err <= 1'b1;
    end
  end

  assign SeqErr = seq_err;
`else
  logic unused_cnt_value;
  assign unused_cnt_value = ^CntValue;
  assign SeqErr = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: drives request rounds against a behavioural Gray counter
// and scores every Done against an arithmetic reference model of the job stream.
module tb_gray_step_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 10;  // {req[9:8], steps[7:5], value[4:2], ovf[1], wrap[0]}

  logic              Clk;
  logic              Reset;
  logic [NREQ-1:0]   Req;
  logic [3*NREQ-1:0] Steps;
  logic [NREQ-1:0]   Gnt, Done;
  logic              WrapNew, Busy, CntEn, CntReset, CntOverflow, SeqErr;
  logic [2:0]        CntValue;
  logic [1:0]        DbgState;

  gray_step_arbiter #(.NREQ(NREQ)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Steps(Steps), .Gnt(Gnt), .Done(Done),
    .WrapNew(WrapNew), .Busy(Busy), .CntEn(CntEn), .CntReset(CntReset),
    .CntOverflow(CntOverflow), .CntValue(CntValue), .SeqErr(SeqErr), .DbgState(DbgState)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- counter environment ----------------
  logic [2:0] cnt_bin    = 3'd0;
  logic       cnt_ovf    = 1'b0;
  logic       glitch     = 1'b0;
  logic       glitch_arm = 1'b0;

  always @(posedge Clk) begin
    if (CntReset) begin
      cnt_bin <= 3'd0;
      cnt_ovf <= 1'b0;
    end else if (CntEn) begin
      if (cnt_bin == 3'd7) cnt_ovf <= 1'b1;
      cnt_bin <= cnt_bin + 3'd1;
    end
    glitch <= glitch_arm & CntEn;
  end

  assign CntValue    = glitch ? 3'b010 : (cnt_bin ^ (cnt_bin >> 1));
  assign CntOverflow = cnt_ovf;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_ptr, m_bin;
  bit m_ovf;
  bit seq_exp = 1'b0;
  int plan[NREQ][4];
  int nplan[NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gray_of(input int b);
    return 3'(b ^ (b >> 1));
  endfunction

  // Reference: total steps taken modulo 8, overflow when the total passes 7.
  function automatic void model_job(input int r, input int n);
    int nb;
    bit wrap;
    logic [W-1:0] e;
    wrap = 1'b0;
    if (n == 0) begin
      m_bin = 0;
      m_ovf = 1'b0;
    end else begin
      nb = m_bin + n;
      if (nb >= 8) begin
        wrap  = !m_ovf;
        m_ovf = 1'b1;
      end
      m_bin = nb % 8;
    end
    e = {2'(r), 3'(n), gray_of(m_bin), m_ovf, wrap};
    exp_q.push_back(e);
    m_ptr = r;
  endfunction

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  int mon_r, mon_n, en_cnt, rst_cnt, gnt_cyc, idle_cyc;
  bit gap_pending;

  initial begin
    en_cnt = 0; rst_cnt = 0; gnt_cyc = 0; idle_cyc = 0; gap_pending = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        en_cnt = 0; rst_cnt = 0; gnt_cyc = 0; idle_cyc = 0; gap_pending = 1'b0;
      end else begin
        if (Busy) chk("en_rst_exclusive", 32'(CntEn & CntReset), 32'd0);
        if (Gnt != '0) begin
          if (gap_pending) begin
            chk("idle_gap", idle_cyc, 32'd1);
            gap_pending = 1'b0;
          end
          gnt_cyc++;
        end else if (!Busy) begin
          idle_cyc++;
        end
        if (CntEn) en_cnt++;
        if (CntReset) rst_cnt++;
        if (Done != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(Done), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            mon_r = int'(mon_e[9:8]);
            mon_n = int'(mon_e[7:5]);
            chk("done_onehot", 32'(Done), 32'd1 << mon_r);
            chk("gnt_held", 32'(Gnt), 32'd1 << mon_r);
            chk("cnt_value", 32'(CntValue), 32'(mon_e[4:2]));
            chk("cnt_overflow", 32'(CntOverflow), 32'(mon_e[1]));
            chk("wrap_new", 32'(WrapNew), 32'(mon_e[0]));
            chk("en_cycles", en_cnt, mon_n);
            chk("rst_cycles", rst_cnt, (mon_n == 0) ? 32'd1 : 32'd0);
            chk("gnt_cycles", gnt_cyc, (mon_n == 0) ? 32'd3 : 32'(mon_n + 2));
            chk("seq_err", 32'(SeqErr), 32'(seq_exp));
            gap_pending = (exp_q.size() != 0);
          end
          en_cnt = 0; rst_cnt = 0; gnt_cyc = 0; idle_cyc = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_plan();
    for (int r = 0; r < NREQ; r++) nplan[r] = 0;
  endtask

  task automatic add(input int r, input int n);
    plan[r][nplan[r]] = n;
    nplan[r]++;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    Req   = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    m_ptr = NREQ - 1;
  endtask

  // All planned requesters raise Req together and hold it while jobs remain.
  task automatic run_round(input bit early, input bit glitch_job);
    int used[NREQ];
    int cur[NREQ];
    int left, total, budget, r;
    logic [W-1:0] e;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      used[i] = 0;
      cur[i]  = 0;
      total  += nplan[i];
    end
    left = total;
    while (left > 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        r = (m_ptr + k) % NREQ;
        if (used[r] < nplan[r]) begin
          model_job(r, plan[r][used[r]]);
          used[r]++;
          left--;
          break;
        end
      end
    end
    if (glitch_job) begin
      e = exp_q.pop_back();
      e[4:2] = 3'b010;
      exp_q.push_back(e);
      glitch_arm = 1'b1;
    end
    @(negedge Clk);
    for (int i = 0; i < NREQ; i++) begin
      if (nplan[i] > 0) begin
        Req[i] = 1'b1;
        Steps[3*i +: 3] = 3'(plan[i][0]);
      end
    end
    left = total;
    budget = 0;
    while (left > 0 && budget < 400) begin
      @(negedge Clk);
      budget++;
      for (int i = 0; i < NREQ; i++) begin
        if (Done[i]) begin
          cur[i]++;
          left--;
          if (cur[i] < nplan[i]) Steps[3*i +: 3] = 3'(plan[i][cur[i]]);
          else Req[i] = 1'b0;
        end else if (early && Gnt[i] && (CntEn || CntReset)) begin
          Steps[3*i +: 3] = 3'($urandom_range(0, 7));
          if (cur[i] == nplan[i] - 1) Req[i] = 1'b0;
        end
      end
    end
    glitch_arm = 1'b0;
    chk("round_done", left, 32'd0);
    if (left > 0) begin
      exp_q.delete();
      do_reset();
      m_bin = int'(cnt_bin);
      m_ovf = cnt_ovf;
    end
    repeat (3) @(negedge Clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
  endtask

  // Reset lands while the third En of a 5-step job is being driven.
  task automatic abort_test();
    int n_en, budget, nb;
    n_en = 0;
    budget = 0;
    @(negedge Clk);
    Req[1] = 1'b1;
    Steps[5:3] = 3'd5;
    while (n_en < 2 && budget < 20) begin
      @(negedge Clk);
      budget++;
      if (CntEn) n_en++;
    end
    chk("abort_en_seen", n_en, 32'd2);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    Req   = '0;
    #1;
    chk("abort_cnt_en", 32'(CntEn), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_gnt", 32'(Gnt), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    nb = m_bin + n_en;
    if (nb >= 8) m_ovf = 1'b1;
    m_bin = nb % 8;
    m_ptr = NREQ - 1;
    repeat (4) @(negedge Clk);
    chk("abort_cnt_value", 32'(CntValue), 32'(gray_of(m_bin)));
  endtask

  // ---------------- main sequence ----------------
  int nj, tot;

  initial begin
    Reset = 1'b1;
    Req   = '0;
    Steps = '0;
    m_ptr = NREQ - 1;
    m_bin = 0;
    m_ovf = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("rst_gnt", 32'(Gnt), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_cnt_en", 32'(CntEn), 32'd0);
    chk("rst_cnt_reset", 32'(CntReset), 32'd0);
    chk("rst_wrap_new", 32'(WrapNew), 32'd0);
    chk("rst_seq_err", 32'(SeqErr), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    clear_plan(); add(0, 3); run_round(1'b0, 1'b0);
    abort_test();
    clear_plan(); add(0, 2); add(0, 2); add(1, 1); run_round(1'b0, 1'b0);
    clear_plan(); add(2, 0); run_round(1'b0, 1'b0);
    clear_plan(); add(0, 6); run_round(1'b0, 1'b0);
    clear_plan(); add(1, 2); run_round(1'b0, 1'b0);
    clear_plan(); add(0, 1); run_round(1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      clear_plan();
      tot = 0;
      for (int r = 0; r < NREQ; r++) begin
        nj = int'($urandom_range(0, 3));
        for (int j = 0; j < nj; j++) add(r, int'($urandom_range(0, 7)));
        tot += nj;
      end
      if (tot == 0) add(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 7)));
      run_round(1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef GRAY_SEQ_CHECK_EN
    clear_plan(); add(2, 0); run_round(1'b0, 1'b0);
    clear_plan(); add(0, 1); run_round(1'b0, 1'b0);
    clear_plan(); add(0, 1); run_round(1'b0, 1'b1);
    seq_exp = 1'b1;
    repeat (3) @(negedge Clk);
    chk("seq_err_set", 32'(SeqErr), 32'd1);
    clear_plan(); add(1, 1); run_round(1'b0, 1'b0);
    do_reset();
    seq_exp = 1'b0;
    #1;
    chk("seq_err_cleared", 32'(SeqErr), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
